// File: rtl/mips_data_mem_responder.sv
// Data-bus responder for the mips core: byte-enable RAM plus LED/cycle/status MMIO, zeroed after reset.
// Zero-latency combinational reads, writes commit on the edge; never stalls the core.
module mips_data_mem_responder #(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int LED_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        we,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  output logic              init_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic [31:0]         cyc_q, cyc_d;
  logic [31:0]         mem [DEPTH];

  logic                is_mmio;
  logic [ADDR_W-1:0]   ram_idx;
  logic                sel_led, sel_cyc, sel_sts;
  logic                mem_wr_en;
  logic [ADDR_W-1:0]   mem_wr_idx;
  logic [31:0]         mem_wr_dat;
  logic [3:0]          mem_wr_be;
  logic [31:0]         led_ext, led_wr;
  logic                unused_ok;

  assign is_mmio   = (addr[31:28] == 4'hF);
  assign ram_idx   = addr[ADDR_W+1:2];
  assign sel_led   = is_mmio && (addr[27:2] == 26'd0);
  assign sel_cyc   = is_mmio && (addr[27:2] == 26'd1);
  assign sel_sts   = is_mmio && (addr[27:2] == 26'd2);
  assign unused_ok = &{1'b0, addr[1:0]};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? S_INIT : S_READY;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == S_INIT) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (&clr_idx_q) state_d = S_READY;
    end
  end

  // FSM: outputs -- the clear sequence owns the RAM write port while in INIT
  always_comb begin
    init_done  = (state_q == S_READY);
    mem_wr_en  = 1'b0;
    mem_wr_idx = ram_idx;
    mem_wr_dat = wdata;
    mem_wr_be  = we;
    if (state_q == S_INIT) begin
      mem_wr_en  = 1'b1;
      mem_wr_idx = clr_idx_q;
      mem_wr_dat = '0;
      mem_wr_be  = 4'hF;
    end else if (!is_mmio && (we != 4'h0)) begin
      mem_wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wr_be[i]) mem[mem_wr_idx][8*i +: 8] <= mem_wr_dat[8*i +: 8];
      end
    end
  end

  always_comb begin
    led_ext = 32'(led_q);
    led_wr  = led_ext;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) led_wr[8*i +: 8] = wdata[8*i +: 8];
    end
    led_d = sel_led ? led_wr[LED_W-1:0] : led_q;
    cyc_d = (sel_cyc && (we != 4'h0)) ? 32'd0 : cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      cyc_q <= '0;
    end else begin
      led_q <= led_d;
      cyc_q <= cyc_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel_led)      rdata = led_ext;
    else if (sel_cyc) rdata = cyc_q;
    else if (sel_sts) rdata = {31'd0, init_done};
    else if (!is_mmio && (state_q == S_READY)) rdata = mem[ram_idx];
  end

  assign led = led_q;

endmodule
